// File: rtl/multiplier_ctrl_pkg.sv
// Shared definitions for the radix-16 Booth multiplier.
// The controller and the datapath both import this package. It defines:
//   state_t    - controller state encoding, which the datapath also decodes
//   EXEC_STEPS - number of radix-16 Booth steps for a 16-bit multiplier
//   LAST_STEP  - value of count on the final EXEC cycle
package multiplier_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    OUT  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int         EXEC_STEPS = 4;
  localparam int         RADIX_BITS = 4;
  localparam logic [2:0] LAST_STEP  = 3'(EXEC_STEPS - 1);

endpackage

// File: rtl/multiplier_ctrl_if.sv
// Bus between the multiplier controller, its host and the Booth datapath.
// The slave modport is the controller's view of the bus. The master modport
// is the view seen by the host and the datapath.
//   op_start, op_clear      - host start request and abort/acknowledge
//   multiplicand            - signed operand; only [15:0] is significant
//   multiplier              - 16-bit signed operand
//   next_result             - per-step accumulator value from the datapath
//   multiplicand_q          - operand latched at start, sent to the datapath
//   check_radix             - current 5-bit Booth window
//   count                   - EXEC step index
//   state                   - controller state
//   result                  - accumulator; holds the product while done=1
//   done                    - high while the controller is in DONE
interface multiplier_ctrl_if;
  import multiplier_ctrl_pkg::*;

  logic        op_start;
  logic        op_clear;
  logic [31:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] next_result;
  logic [31:0] multiplicand_q;
  logic [4:0]  check_radix;
  logic [2:0]  count;
  state_t      state;
  logic [31:0] result;
  logic        done;

  modport master (
    output op_start, op_clear, multiplicand, multiplier, next_result,
    input  multiplicand_q, check_radix, count, state, result, done
  );

  modport slave (
    input  op_start, op_clear, multiplicand, multiplier, next_result,
    output multiplicand_q, check_radix, count, state, result, done
  );

endinterface

// File: rtl/multiplier_ctrl.sv
// Control unit for a radix-16 Booth multiplier. It sequences four EXEC steps
// over a 16-bit signed multiplier and then presents the 32-bit product.
//   clk    - single clock; all state changes on its rising edge
//   reset  - synchronous, active-high
//   bus    - slave side of multiplier_ctrl_if; the datapath that turns
//            (check_radix, count, multiplicand_q, result) into next_result
//            is connected at the level above this block
module multiplier_ctrl
  import multiplier_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  multiplier_ctrl_if.slave bus
);

  state_t      state_q,  state_d;
  logic [2:0]  count_q,  count_d;
  logic [31:0] result_q, result_d;
  logic [31:0] mcand_q,  mcand_d;
  logic [16:0] shift_q,  shift_d;

  // Register stage for every piece of controller state. Reset wins over all
  // inputs, so an op_start seen in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      mcand_q  <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state logic. Every register holds by default. op_clear is tested
  // before op_start everywhere, so an abort always wins. A clear from EXEC
  // leaves result untouched for one cycle; IDLE then forces it to zero.
  // The shift register carries the multiplier with an appended zero (the
  // Booth bit -1). It moves right by one radix digit per step, with sign
  // fill, so its low five bits are always the current Booth window.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    mcand_d  = mcand_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: begin
        result_d = '0;
        if (!bus.op_clear && bus.op_start) begin
          mcand_d = bus.multiplicand;
          shift_d = {bus.multiplier, 1'b0};
          count_d = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (bus.op_clear) begin
          state_d = IDLE;
        end else begin
          result_d = bus.next_result;
          shift_d  = {{RADIX_BITS{shift_q[16]}}, shift_q[16:RADIX_BITS]};
          count_d  = count_q + 3'd1;
          if (count_q == LAST_STEP) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        state_d = bus.op_clear ? IDLE : DONE;
      end
      DONE: begin
        if (bus.op_clear) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        result_d = '0;
      end
    endcase
  end

  assign bus.check_radix    = shift_q[4:0];
  assign bus.multiplicand_q = mcand_q;
  assign bus.count          = count_q;
  assign bus.state          = state_q;
  assign bus.result         = result_q;
  assign bus.done           = (state_q == DONE);

endmodule
